alu_seq: RTL and testbench

//  Parametrised, registered ALU for the RISC-V core's execute stage: extended op set (logic, shifts, compares), optional iterative multiplier.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 69 ++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq execute-stage ALU: opcodes, FSM states and
// the multiplier latency helper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b0010;
  localparam logic [3:0] ALU_PASS_B = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_SLL    = 4'b0110;
  localparam logic [3:0] ALU_SRL    = 4'b0111;
  localparam logic [3:0] ALU_SRA    = 4'b1000;
  localparam logic [3:0] ALU_SLT    = 4'b1001;
  localparam logic [3:0] ALU_SLTU   = 4'b1010;
  localparam logic [3:0] ALU_MUL    = 4'b1011;
  localparam logic [3:0] ALU_MULHU  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

  // Edges from accept to result load for a multiply, counting the accept edge.
  function automatic int mul_latency(input int xlen, input int mul_step);
    return xlen / mul_step + 1;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Only built when ALU_MUL_EN is defined; alu_seq owns handshake and output register.
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] prod
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LAST  = mul_latency(XLEN, MUL_STEP) - 2;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
  end

  // The final partial sum is presented combinationally so the result loads on the last step edge.
  assign done = busy_q && (cnt_q == CW'(LAST));
  assign prod = acc_d;
  assign busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready on both sides and a one-entry output register.
// ALU_MUL_EN enables MUL/MULHU via alu_mul_iter; otherwise those opcodes report illegal.
//
// state   | meaning
// ST_IDLE | ready for a new op (if the output register is free or draining)
// ST_BUSY | multiply in progress, in_ready held low
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            zero,
  output logic            illegal
);

  localparam int SH_W = $clog2(XLEN);

  if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
    $error("alu_seq: XLEN must be a power of two >= 8");
  end
  if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) || (XLEN % MUL_STEP) != 0) begin : g_bad_step
    $error("alu_seq: MUL_STEP must be 1, 2 or 4 and divide XLEN");
  end

  alu_state_e        state_q, state_d;
  logic              accept, is_mul_op, mul_start, mul_done, mul_busy, load;
  logic              op_hi_q;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   alu_res, load_res;
  logic              alu_carry, alu_illegal, load_carry, load_illegal;
  logic [SH_W-1:0]   shamt;

`ifdef ALU_MUL_EN
  assign is_mul_op = (alu_control == ALU_MUL) || (alu_control == ALU_MULHU);

  alu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul_op = 1'b0;
  assign mul_busy  = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_prod  = '0;
`endif

  assign in_ready  = (state_q == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul_op;
  assign load      = (accept && !is_mul_op) || mul_done;
  assign shamt     = b[SH_W-1:0];

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (alu_control)
      ALU_ADD:    {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
      ALU_SUB:    {alu_carry, alu_res} = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
      ALU_XOR:    alu_res = a ^ b;
      ALU_PASS_B: alu_res = b;
      ALU_AND:    alu_res = a & b;
      ALU_OR:     alu_res = a | b;
      ALU_SLL:    alu_res = a << shamt;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a < b};
      // MUL/MULHU land here too; with the multiplier built they never load from this path.
      default:    alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    load_res     = alu_res;
    load_carry   = alu_carry;
    load_illegal = alu_illegal;
    if (mul_done) begin
      load_res     = op_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
      load_carry   = 1'b0;
      load_illegal = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_BUSY;
      ST_BUSY: if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mul_start) op_hi_q <= (alu_control == ALU_MULHU);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      carry     <= load_carry;
      zero      <= (load_res == '0);
      illegal   <= load_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, back-pressure, reset
// mid-operation and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic            ill;
    logic            cy;
    logic [XLEN-1:0] res;
  } ref_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [3:0]      alu_control = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            carry, zero, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [XLEN-1:0] obs_res;
  logic            obs_carry, obs_illegal;

  alu_seq #(.XLEN(XLEN), .MUL_STEP(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry       (carry),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ref_t model(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    ref_t        r;
    logic [63:0] ux, uy, p;
    int          sh;
    r  = '0;
    ux = {32'd0, x};
    uy = {32'd0, y};
    p  = ux * uy;
    sh = int'(y % XLEN);
    case (op)
      4'd0:  begin r.res = x + y; r.cy = ((ux + uy) >> XLEN) != 0; end
      4'd1:  begin r.res = x - y; r.cy = (x >= y); end
      4'd2:  r.res = x ^ y;
      4'd3:  r.res = y;
      4'd4:  r.res = x & y;
      4'd5:  r.res = x | y;
      4'd6:  r.res = x << sh;
      4'd7:  r.res = x >> sh;
      4'd8:  r.res = (x >> sh) | (x[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
      4'd9:  r.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd10: r.res = (x < y) ? 1 : 0;
      4'd11: if (MUL_EN) r.res = p[XLEN-1:0];      else r.ill = 1'b1;
      4'd12: if (MUL_EN) r.res = p[2*XLEN-1:XLEN]; else r.ill = 1'b1;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Present an op and hold it until accepted; returns on the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    int t;
    t = 0;
    in_valid = 1'b1;
    alu_control = op;
    a = x;
    b = y;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_in_time", t < 100, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input string tag);
    ref_t e;
    int   waits;
    e = model(op, x, y);
    issue(op, x, y);
    waits = 0;
    while (!out_valid && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, "_lat"}, waits, (MUL_EN && (op == ALU_MUL || op == ALU_MULHU)) ? XLEN : 0);
    obs_res = result;
    obs_carry = carry;
    obs_illegal = illegal;
    chk({tag, "_res"}, result, e.res);
    chk({tag, "_carry"}, carry, e.cy);
    chk({tag, "_zero"}, zero, e.res == 0);
    chk({tag, "_illegal"}, illegal, e.ill);
  endtask

  function automatic logic [XLEN-1:0] rnd_operand();
    logic [XLEN-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = {1'b1, {(XLEN-1){1'b0}}};
    corners[3] = 1;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);

    run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    chk("add_wrap_const_res", obs_res, 0);
    chk("add_wrap_const_cy", obs_carry, 1);
    run_op(ALU_SUB, 32'd5, 32'd7, "sub_neg");
    chk("sub_neg_const_res", obs_res, 32'hFFFF_FFFE);
    chk("sub_neg_const_cy", obs_carry, 0);
    run_op(ALU_SUB, 32'd7, 32'd7, "sub_eq");
    chk("sub_eq_const_cy", obs_carry, 1);
    run_op(ALU_SRA, 32'h8000_0000, 32'h0000_0024, "sra");
    chk("sra_const_res", obs_res, 32'hF800_0000);
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, "slt");
    chk("slt_const_res", obs_res, 1);
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu");
    chk("sltu_const_res", obs_res, 0);
    run_op(ALU_MUL, 32'h0001_0000, 32'h0003_0000, "mul");
    chk("mul_const_res", obs_res, 0);
    chk("mul_const_ill", obs_illegal, !MUL_EN);
    run_op(ALU_MULHU, 32'h0001_0000, 32'h0003_0000, "mulhu");
    chk("mulhu_const_res", obs_res, MUL_EN ? 3 : 0);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, "ill_f");
    chk("ill_f_const_ill", obs_illegal, 1);
    chk("ill_f_const_res", obs_res, 0);

    @(negedge clk);
    chk("drain_before_bp", out_valid, 0);
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_res", result, 3);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_control = ALU_XOR;
    a = 32'h0000_F0F0;
    b = 32'h0000_FF00;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_res", result, 32'h0000_0FF0);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    out_ready = 1'b0;
    issue(ALU_MUL, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midop_no_valid", seen, 0);
    chk("midop_in_ready", in_ready, 1);
    run_op(ALU_ADD, 32'd10, 32'd20, "add_after_rst");
    chk("add_after_rst_const", obs_res, 30);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op(op, rnd_operand(), rnd_operand(), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
